// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - paddle game sequencer: play FSM, ball gating, score and lives
//
// Ports:
//   clck        in   system clock, rising edge
//   reset       in   synchronous, active-high
//   frame_tick  in   one-cycle pulse per frame (start of vertical blank)
//   start_btn   in   debounced, synchronised start/pause level
//   ball_y      in   ball top-edge y
//   ball_hit    in   one-cycle pulse on paddle bounce
//   ball_reset  out  holds the ball block at its serve position
//   ball_update out  one-cycle pulse advancing the ball one step
//   paddle_en   out  paddle may move
//   score       out  saturating paddle-hit count for this game
//   lives       out  remaining lives
//   state       out  IDLE=0 SERVE=1 PLAY=2 PAUSE=3 OVER=4
//   game_over   out  high in OVER
//
// Build option: define GAME_PAUSE_EN to enable the PAUSE state (start_rise
// toggles PLAY <-> PAUSE). Without it, state 3 is treated as illegal.

module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_Y       = 460,
  parameter int SCORE_W      = 8
) (
  input  logic               clck,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic [9:0]         ball_y,
  input  logic               ball_hit,
  output logic               ball_reset,
  output logic               ball_update,
  output logic               paddle_en,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic [2:0]         state,
  output logic               game_over
);

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

  localparam logic [CNT_W-1:0] SERVE_END  = CNT_W'(SERVE_FRAMES);
  localparam logic [9:0]       MISS_LINE  = 10'(MISS_Y);
  localparam logic [3:0]       LIVES_INIT = 4'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t           st;
  logic             start_q;
  logic [CNT_W-1:0] serve_cnt;
  logic             start_rise;
  logic             miss;

  assign start_rise = start_btn & ~start_q;
  assign miss       = (ball_y >= MISS_LINE);
  assign state      = st;

  always_ff @(posedge clck) begin
    if (reset) begin
      st          <= S_IDLE;
      start_q     <= 1'b0;
      serve_cnt   <= '0;
      ball_reset  <= 1'b1;
      ball_update <= 1'b0;
      paddle_en   <= 1'b0;
      score       <= '0;
      lives       <= LIVES_INIT;
      game_over   <= 1'b0;
    end else begin
      start_q     <= start_btn;
      ball_update <= 1'b0;

      case (st)
        S_IDLE, S_OVER: begin
          if (start_rise) begin
            st         <= S_SERVE;
            score      <= '0;
            lives      <= LIVES_INIT;
            serve_cnt  <= '0;
            ball_reset <= 1'b1;
            paddle_en  <= 1'b1;
            game_over  <= 1'b0;
          end
        end

        S_SERVE: begin
          if (frame_tick) begin
            serve_cnt <= serve_cnt + CNT_W'(1);
            // The serve-ending tick only releases the ball; the first
            // ball_update waits for the following frame.
            if (serve_cnt + CNT_W'(1) == SERVE_END) begin
              st         <= S_PLAY;
              ball_reset <= 1'b0;
            end
          end
        end

        S_PLAY: begin
          // Hits count even on the cycle a miss is being processed.
          if (ball_hit && (score != '1)) begin
            score <= score + SCORE_W'(1);
          end

          if (PAUSE_EN && start_rise) begin
            st        <= S_PAUSE;
            paddle_en <= 1'b0;
          end else if (frame_tick) begin
            if (miss) begin
              if (lives != 4'd0) begin
                lives <= lives - 4'd1;
              end
              ball_reset <= 1'b1;
              // Losing the last life ends the game; 0 is treated like 1.
              if (lives <= 4'd1) begin
                st        <= S_OVER;
                paddle_en <= 1'b0;
                game_over <= 1'b1;
              end else begin
                st        <= S_SERVE;
                serve_cnt <= '0;
              end
            end else begin
              ball_update <= 1'b1;
            end
          end
        end

        S_PAUSE: begin
          if (PAUSE_EN) begin
            if (start_rise) begin
              st        <= S_PLAY;
              paddle_en <= 1'b1;
            end
          end else begin
            st         <= S_IDLE;
            ball_reset <= 1'b1;
            paddle_en  <= 1'b0;
            game_over  <= 1'b0;
          end
        end

        default: begin
          st         <= S_IDLE;
          ball_reset <= 1'b1;
          paddle_en  <= 1'b0;
          game_over  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - randomized scoreboard bench for game_ctrl

module tb_game_ctrl;

  localparam int LIVES        = 3;
  localparam int SERVE_FRAMES = 60;
  localparam int MISS_Y       = 460;
  localparam int SCORE_W      = 8;
  localparam int SCORE_MAX    = (1 << SCORE_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_PAUSE = 3;
  localparam int M_OVER  = 4;

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic               clck = 1'b0;
  logic               reset = 1'b1;
  logic               frame_tick = 1'b0;
  logic               start_btn = 1'b0;
  logic [9:0]         ball_y = '0;
  logic               ball_hit = 1'b0;
  logic               ball_reset;
  logic               ball_update;
  logic               paddle_en;
  logic [SCORE_W-1:0] score;
  logic [3:0]         lives;
  logic [2:0]         state;
  logic               game_over;

  game_ctrl #(
    .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES), .MISS_Y(MISS_Y), .SCORE_W(SCORE_W)
  ) dut (
    .clck(clck), .reset(reset), .frame_tick(frame_tick), .start_btn(start_btn),
    .ball_y(ball_y), .ball_hit(ball_hit), .ball_reset(ball_reset),
    .ball_update(ball_update), .paddle_en(paddle_en), .score(score),
    .lives(lives), .state(state), .game_over(game_over)
  );

  always #5 clck = ~clck;

  typedef struct {
    int ball_reset;
    int ball_update;
    int paddle_en;
    int score;
    int lives;
    int state;
    int game_over;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: game described by its mode plus plain integer counters.
  int m_mode = M_IDLE;
  int m_score = 0;
  int m_lives = LIVES;
  int m_frames = 0;
  bit m_btn_prev = 1'b0;

  task automatic model_step(input bit r, input bit b, input bit t, input int y,
                            input bit h, output exp_t e);
    bit rise;
    bit upd;
    upd = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_score = 0; m_lives = LIVES; m_frames = 0; m_btn_prev = 1'b0;
    end else begin
      rise = b && !m_btn_prev;
      m_btn_prev = b;
      if (m_mode == M_IDLE || m_mode == M_OVER) begin
        if (rise) begin
          m_mode = M_SERVE; m_score = 0; m_lives = LIVES; m_frames = 0;
        end
      end else if (m_mode == M_SERVE) begin
        if (t) begin
          m_frames++;
          if (m_frames == SERVE_FRAMES) m_mode = M_PLAY;
        end
      end else if (m_mode == M_PLAY) begin
        if (h) m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
        if (PAUSE_EN && rise) begin
          m_mode = M_PAUSE;
        end else if (t) begin
          if (y >= MISS_Y) begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_frames = 0;
            m_mode = (m_lives == 0) ? M_OVER : M_SERVE;
          end else begin
            upd = 1'b1;
          end
        end
      end else if (m_mode == M_PAUSE) begin
        if (rise) m_mode = M_PLAY;
      end
    end
    e.ball_reset  = (m_mode == M_IDLE || m_mode == M_SERVE || m_mode == M_OVER) ? 1 : 0;
    e.ball_update = upd ? 1 : 0;
    e.paddle_en   = (m_mode == M_SERVE || m_mode == M_PLAY) ? 1 : 0;
    e.score       = m_score;
    e.lives       = m_lives;
    e.state       = m_mode;
    e.game_over   = (m_mode == M_OVER) ? 1 : 0;
  endtask

  task automatic drive(input bit r, input bit b, input bit t, input int y, input bit h);
    exp_t e;
    @(negedge clck);
    reset = r; start_btn = b; frame_tick = t; ball_y = 10'(y); ball_hit = h;
    model_step(r, b, t, y, h, e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one registered response per driven cycle, sampled after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clck);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ball_reset",  int'(ball_reset),  e.ball_reset);
        chk("ball_update", int'(ball_update), e.ball_update);
        chk("paddle_en",   int'(paddle_en),   e.paddle_en);
        chk("score",       int'(score),       e.score);
        chk("lives",       int'(lives),       e.lives);
        chk("state",       int'(state),       e.state);
        chk("game_over",   int'(game_over),   e.game_over);
      end
    end
  end

  function automatic int pick_y();
    case ($urandom_range(0, 9))
      0:       return MISS_Y;
      1:       return MISS_Y - 1;
      2:       return int'($urandom_range(MISS_Y + 1, 1023));
      default: return int'($urandom_range(0, MISS_Y - 2));
    endcase
  endfunction

  task automatic random_phase(input int cycles, input int btn_odds, input int hit_odds,
                              input bit allow_miss, input int reset_odds);
    bit btn;
    btn = start_btn;
    for (int i = 0; i < cycles; i++) begin
      if (btn_odds > 0 && $urandom_range(0, btn_odds - 1) == 0) btn = !btn;
      drive((reset_odds > 0) && ($urandom_range(0, reset_odds - 1) == 0), btn,
            $urandom_range(0, 3) == 0,
            allow_miss ? pick_y() : int'($urandom_range(0, MISS_Y - 1)),
            $urandom_range(0, hit_odds - 1) == 0);
    end
  endtask

  initial begin
    repeat (3) drive(1, 0, 0, 0, 0);
    repeat (5) drive(0, 1, 0, 100, 0);
    repeat (2) drive(0, 0, 0, 100, 0);

    // Serve and ordinary play: misses, edge y values, occasional button and reset.
    random_phase(2500, 150, 8, 1'b1, 800);

    // Long rally with dense hits to reach score saturation.
    repeat (2) drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, 100, 0);
    drive(0, 0, 0, 100, 0);
    random_phase(2000, 0, 2, 1'b0, 0);

    // Reset in the middle of play.
    drive(1, 0, 1, 600, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);

    // Frequent button activity (exercises pause when enabled).
    random_phase(2000, 40, 4, 1'b1, 0);

    repeat (3) @(negedge clck);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the paddle game. Owns the play state machine (idle, serve, play, pause, game over), gates the per-frame update strobe to the ball datapath, holds the ball at its serve position between rallies, detects misses past the paddle line, and keeps score and lives counters for the on-screen overlay. Sits between the VGA timing generator and the ball/paddle blocks.

## Interface
Parameters:
- LIVES, 3: lives per game; legal range 1..15.
- SERVE_FRAMES, 60: frame ticks the ball is held before a serve.
- MISS_Y, 460: ball y at or beyond which the paddle has missed.
- SCORE_W, 8: score counter width.

Ports:
- clck  in  1  system clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per frame, at start of vertical blank.
- start_btn  in  1  start/pause button level, already debounced and synchronised.
- ball_y  in  10  current ball top-edge y from the ball block.
- ball_hit  in  1  one-cycle pulse when the ball bounces off the paddle.
- ball_reset  out  1  level; holds the ball block in reset (centred, initial velocity).
- ball_update  out  1  one-cycle pulse; advances the ball one step.
- paddle_en  out  1  level; paddle may move.
- score  out  SCORE_W  paddle hits this game, saturating.
- lives  out  4  remaining lives.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, OVER=4.
- game_over  out  1  high in OVER.

## Operation
- start_rise = start_btn & ~start_q, where start_q is start_btn registered one cycle.
- IDLE: ball_reset=1, paddle_en=0. On start_rise: score=0, lives=LIVES, serve_cnt=0, go to SERVE.
- SERVE: ball_reset=1, paddle_en=1. serve_cnt increments on each frame_tick. On the frame_tick that brings serve_cnt to SERVE_FRAMES, go to PLAY.
- PLAY: ball_reset=0, paddle_en=1. On each frame_tick:
  - If ball_y >= MISS_Y, this is a miss. Do not pulse ball_update. Decrement lives.
  - After a miss, if lives was 1, go to OVER. Otherwise go to SERVE with serve_cnt=0.
  - If there is no miss, pulse ball_update.
- ball_hit in PLAY: score += 1, saturating at all-ones. ball_hit outside PLAY is ignored.
- ball_hit on the same cycle as a miss: score increments and the miss is still processed.
- OVER: ball_reset=1, paddle_en=0, game_over=1; score and lives are frozen. On start_rise, behave as the IDLE exit.
- PAUSE: only exists with PAUSE_EN (see Configuration).
- Illegal state encoding: go to IDLE on the next cycle.
- Arithmetic: the lives decrement never wraps below 0. MISS_Y is compared unsigned against the 10-bit ball_y.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, ball_reset=1, ball_update=0, paddle_en=0, score=0, lives=LIVES, game_over=0, serve_cnt=0, start_q=0.
- ball_update rises in the cycle after the frame_tick that triggers it and lasts exactly one cycle. There is at most one per frame.
- state, lives and ball_reset change in the cycle after the deciding frame_tick or start_rise.
- On SERVE to PLAY, ball_reset falls in the same cycle that state becomes PLAY. The first ball_update comes from the next frame_tick, never from the serve-ending tick.
- score updates in the cycle after ball_hit.
- start_btn held high produces only one start_rise.
- reset mid-game overrides everything: IDLE on the next edge, with all reset values.

## Configuration
- GAME_PAUSE_EN defined:
  - start_rise in PLAY goes to PAUSE. start_rise in PAUSE returns to PLAY.
  - In PAUSE: ball_reset=0, ball_update never pulses, paddle_en=0, frame_tick and ball_hit are ignored, and score and lives are held.
- GAME_PAUSE_EN undefined:
  - start_btn is ignored in SERVE and PLAY.
  - State 3 is unreachable and is treated as illegal.

## Test plan
- Reset, then start_btn held high for 5 cycles: exactly one transition to SERVE; lives=3, score=0; ball_reset stays 1 for 60 frame_ticks, then state=PLAY.
- PLAY with ball_y=200 over 10 frame_ticks: 10 single-cycle ball_update pulses, each one cycle after its tick.
- PLAY, ball_y=460 at frame_tick: no ball_update, lives 3→2, state=SERVE, ball_reset=1. Repeat for the third miss: lives=0, state=OVER, game_over=1.
- 300 ball_hit pulses with SCORE_W=8: score saturates at 255. A hit coincident with a miss tick: score +1 and lives -1 in the same cycle.
- With GAME_PAUSE_EN: start_rise in PLAY, then 5 frame_ticks and 2 ball_hits: no ball_update, score unchanged; a second start_rise resumes PLAY.
- Assert reset in mid-PLAY with score=7: the next cycle shows all reset values and state=IDLE.
